// File: rtl/coincidence_gate_counter_if.sv
// Bus bundle for the coincidence gate counter: run control, channel inputs
// and the count/status readback.
interface coincidence_gate_counter_if #(
  parameter int NCHAN = 4,
  parameter int CNTW  = 16,
  parameter int CYCW  = 16,
  parameter int DLYW  = 4,
  parameter int WINW  = 4
);
  localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2;

  logic                      Start_i;
  logic                      Abort_i;
  logic [CYCW-1:0]           nCycles_i;
  logic [WINW-1:0]           Window_i;
  logic [NCHAN*DLYW-1:0]     Delays_i;
  logic [NCHAN-1:0]          Channels;
  logic                      Busy_o;
  logic                      Done_o;
  logic [CYCW-1:0]           Cnt_Clk;
  logic [NCHAN*CNTW-1:0]     Cnt_chann;
  logic [NPAIRS*CNTW-1:0]    Cnt_pairs;
  logic [NCHAN+NPAIRS-1:0]   Overflow_o;

  modport master (
    output Start_i, Abort_i, nCycles_i, Window_i, Delays_i, Channels,
    input  Busy_o, Done_o, Cnt_Clk, Cnt_chann, Cnt_pairs, Overflow_o
  );

  modport slave (
    input  Start_i, Abort_i, nCycles_i, Window_i, Delays_i, Channels,
    output Busy_o, Done_o, Cnt_Clk, Cnt_chann, Cnt_pairs, Overflow_o
  );
endinterface

// File: rtl/coincidence_gate_counter.sv
// Gated coincidence counter: synchronised edge detection, per-channel delay
// alignment, coincidence windows, saturating single and pair counters.
module coincidence_gate_counter #(
  parameter int NCHAN = 4,
  parameter int CNTW  = 16,
  parameter int CYCW  = 16,
  parameter int DLYW  = 4,
  parameter int WINW  = 4
) (
  input logic                     Clk,
  input logic                     Rst,
  coincidence_gate_counter_if.slave bus
);
  localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2;
  localparam int DEPTH  = (1 << DLYW) - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_next;
  logic                    start_run;
  logic                    count_en;
  logic [CYCW-1:0]         n_cycles;
  logic [CYCW-1:0]         cnt_clk;
  logic [WINW-1:0]         win;
  logic [NCHAN*DLYW-1:0]   dly;
  logic [NCHAN-1:0]        s1, s2, s2_d, p;
  logic [NCHAN-1:0]        q, open;
  logic [NCHAN*CNTW-1:0]   chan_vec;
  logic [NPAIRS*CNTW-1:0]  pair_vec;
  logic [NCHAN+NPAIRS-1:0] ovf_vec;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Abort wins over end-of-gate; Start is only honoured outside RUN
  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    count_en   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.Start_i) begin
          start_run  = 1'b1;
          state_next = (bus.nCycles_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.Abort_i) begin
          state_next = IDLE;
        end else begin
          count_en = 1'b1;
          if (cnt_clk + CYCW'(1) == n_cycles) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      n_cycles <= '0;
      win      <= '0;
      dly      <= '0;
      cnt_clk  <= '0;
    end else if (start_run) begin
      n_cycles <= bus.nCycles_i;
      win      <= bus.Window_i;
      dly      <= bus.Delays_i;
      cnt_clk  <= '0;
    end else if (count_en) begin
      cnt_clk  <= cnt_clk + CYCW'(1);
    end
  end

  // Two-flop synchroniser followed by a registered rising-edge detect
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1   <= '0;
      s2   <= '0;
      s2_d <= '0;
      p    <= '0;
    end else begin
      s1   <= bus.Channels;
      s2   <= s1;
      s2_d <= s2;
      p    <= s2 & ~s2_d;
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_ch
    logic [DEPTH-1:0] line;
    logic [WINW-1:0]  wc;
    logic [DLYW-1:0]  d;
    logic [CNTW-1:0]  cnt;
    logic             ovf;

    assign d       = dly[i*DLYW +: DLYW];
    assign q[i]    = (d == '0) ? p[i] : line[d - 1'b1];
    assign open[i] = q[i] | (wc != '0);

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)            line <= '0;
      else if (start_run) line <= '0;
      else                line <= (line << 1) | DEPTH'(p[i]);
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)             wc <= '0;
      else if (start_run)  wc <= '0;
      else if (q[i])       wc <= win;
      else if (wc != '0)   wc <= wc - 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (start_run) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (count_en && q[i]) begin
        if (cnt == '1) ovf <= 1'b1;
        else           cnt <= cnt + 1'b1;
      end
    end

    assign chan_vec[i*CNTW +: CNTW] = cnt;
    assign ovf_vec[i]               = ovf;
  end

  // Pair index k enumerates (i,j), i<j, in lexicographic order
  for (genvar i = 0; i < NCHAN - 1; i++) begin : g_pi
    for (genvar j = i + 1; j < NCHAN; j++) begin : g_pj
      localparam int K = i * NCHAN - i * (i + 1) / 2 + (j - i - 1);
      logic [CNTW-1:0] cnt;
      logic            ovf;
      logic            hit;

      assign hit = open[i] & open[j] & (q[i] | q[j]);

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          cnt <= '0;
          ovf <= 1'b0;
        end else if (start_run) begin
          cnt <= '0;
          ovf <= 1'b0;
        end else if (count_en && hit) begin
          if (cnt == '1) ovf <= 1'b1;
          else           cnt <= cnt + 1'b1;
        end
      end

      assign pair_vec[K*CNTW +: CNTW] = cnt;
      assign ovf_vec[NCHAN + K]       = ovf;
    end
  end

  assign bus.Busy_o     = (state == RUN);
  assign bus.Done_o     = (state == DONE);
  assign bus.Cnt_Clk    = cnt_clk;
  assign bus.Cnt_chann  = chan_vec;
  assign bus.Cnt_pairs  = pair_vec;
  assign bus.Overflow_o = ovf_vec;
endmodule

// File: tb/tb_coincidence_gate_counter.sv
// Directed bench for coincidence_gate_counter using 4-bit counters so that
// saturation is reachable in a short run.
module tb_coincidence_gate_counter;
  localparam int NCHAN  = 4;
  localparam int CNTW   = 4;
  localparam int CYCW   = 16;
  localparam int DLYW   = 4;
  localparam int WINW   = 4;
  localparam int NPAIRS = 6;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;

  coincidence_gate_counter_if #(
    .NCHAN(NCHAN), .CNTW(CNTW), .CYCW(CYCW), .DLYW(DLYW), .WINW(WINW)
  ) bus ();

  coincidence_gate_counter #(
    .NCHAN(NCHAN), .CNTW(CNTW), .CYCW(CYCW), .DLYW(DLYW), .WINW(WINW)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each helper assumes it is entered just after a falling edge.
  task automatic step(input logic [NCHAN-1:0] ch);
    bus.Channels = ch;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_start(input int n, input int w, input logic [NCHAN*DLYW-1:0] d);
    bus.nCycles_i = CYCW'(n);
    bus.Window_i  = WINW'(w);
    bus.Delays_i  = d;
    bus.Start_i   = 1'b1;
    @(negedge clk);
    bus.Start_i   = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input int limit);
    int guard = 0;
    while (bus.Done_o !== 1'b1 && guard < limit) begin
      step('0);
      guard++;
    end
    vectors++;
    if (bus.Done_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wait_done: Done_o=%b required 1 within %0d cycles", bus.Done_o, limit);
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (bus.Busy_o !== 1'b0 || bus.Done_o !== 1'b0 || bus.Cnt_Clk !== '0 ||
        bus.Cnt_chann !== '0 || bus.Cnt_pairs !== '0 || bus.Overflow_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: busy=%b done=%b clk=%h ch=%h pr=%h ovf=%h required all 0",
               bus.Busy_o, bus.Done_o, bus.Cnt_Clk, bus.Cnt_chann, bus.Cnt_pairs, bus.Overflow_o);
    end
    rst = 1'b0;
    step('0);
  endtask

  task automatic test_basic_pair;
    do_start(40, 0, '0);
    vectors++;
    if (bus.Busy_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy: got %b required 1", bus.Busy_o);
    end
    while (cyc < 39) begin
      if (cyc == 2 || cyc == 6 || cyc == 10) step(4'b0011);
      else                                   step(4'b0000);
    end
    vectors++;
    if (bus.Done_o !== 1'b0 || bus.Cnt_Clk !== 16'd39) begin
      miscompares++;
      $display("[TB] FAIL basic_cycle39: done=%b clk=%0d required done=0 clk=39", bus.Done_o, bus.Cnt_Clk);
    end
    step('0);
    vectors++;
    if (bus.Done_o !== 1'b1 || bus.Busy_o !== 1'b0 || bus.Cnt_Clk !== 16'd40) begin
      miscompares++;
      $display("[TB] FAIL basic_cycle40: done=%b busy=%b clk=%0d required done=1 busy=0 clk=40",
               bus.Done_o, bus.Busy_o, bus.Cnt_Clk);
    end
    vectors++;
    if (bus.Cnt_chann !== 16'h0033 || bus.Cnt_pairs !== 24'h000003) begin
      miscompares++;
      $display("[TB] FAIL basic_counts: ch=%h pr=%h required ch=0033 pr=000003", bus.Cnt_chann, bus.Cnt_pairs);
    end
  endtask

  task automatic test_delay_align(input logic [NCHAN*DLYW-1:0] d, input logic [NPAIRS*CNTW-1:0] exp_pairs);
    step('0);
    step('0);
    do_start(20, 0, d);
    step(4'b0000);
    step(4'b0100);
    step(4'b0000);
    step(4'b0000);
    step(4'b1000);
    wait_done(30);
    vectors++;
    if (bus.Cnt_chann !== 16'h1100 || bus.Cnt_pairs !== exp_pairs) begin
      miscompares++;
      $display("[TB] FAIL delay_align d=%h: ch=%h pr=%h required ch=1100 pr=%h",
               d, bus.Cnt_chann, bus.Cnt_pairs, exp_pairs);
    end
  endtask

  task automatic test_window_edge(input int w, input logic [NPAIRS*CNTW-1:0] exp_pairs);
    step('0);
    step('0);
    do_start(20, w, '0);
    step(4'b0000);
    step(4'b0001);
    step(4'b0000);
    step(4'b0010);
    wait_done(30);
    vectors++;
    if (bus.Cnt_chann !== 16'h0011 || bus.Cnt_pairs !== exp_pairs) begin
      miscompares++;
      $display("[TB] FAIL window_edge w=%0d: ch=%h pr=%h required ch=0011 pr=%h",
               w, bus.Cnt_chann, bus.Cnt_pairs, exp_pairs);
    end
  endtask

  task automatic test_three_window;
    step('0);
    step('0);
    do_start(20, 2, '0);
    step(4'b0000);
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    wait_done(30);
    vectors++;
    if (bus.Cnt_chann !== 16'h0111 || bus.Cnt_pairs !== 24'h001011) begin
      miscompares++;
      $display("[TB] FAIL three_window: ch=%h pr=%h required ch=0111 pr=001011", bus.Cnt_chann, bus.Cnt_pairs);
    end
  endtask

  task automatic test_saturation;
    step('0);
    step('0);
    do_start(60, 0, '0);
    for (int k = 0; k < 20; k++) begin
      step(4'b0001);
      step(4'b0000);
    end
    wait_done(40);
    vectors++;
    if (bus.Cnt_chann !== 16'h000F || bus.Overflow_o !== 10'h001 || bus.Cnt_pairs !== '0) begin
      miscompares++;
      $display("[TB] FAIL saturation: ch=%h ovf=%h pr=%h required ch=000f ovf=001 pr=0",
               bus.Cnt_chann, bus.Overflow_o, bus.Cnt_pairs);
    end
  endtask

  task automatic test_zero_length;
    step('0);
    do_start(0, 0, '0);
    vectors++;
    if (bus.Done_o !== 1'b1 || bus.Busy_o !== 1'b0 || bus.Cnt_Clk !== '0 ||
        bus.Cnt_chann !== '0 || bus.Overflow_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL zero_length: done=%b busy=%b clk=%0d ch=%h ovf=%h required done=1 busy=0 rest 0",
               bus.Done_o, bus.Busy_o, bus.Cnt_Clk, bus.Cnt_chann, bus.Overflow_o);
    end
  endtask

  task automatic test_abort;
    step('0);
    do_start(40, 0, '0);
    while (cyc < 10) step('0);
    bus.Abort_i = 1'b1;
    step('0);
    bus.Abort_i = 1'b0;
    vectors++;
    if (bus.Busy_o !== 1'b0 || bus.Done_o !== 1'b0 || bus.Cnt_Clk !== 16'd10) begin
      miscompares++;
      $display("[TB] FAIL abort: busy=%b done=%b clk=%0d required busy=0 done=0 clk=10",
               bus.Busy_o, bus.Done_o, bus.Cnt_Clk);
    end
    bus.Abort_i = 1'b1;
    repeat (35) step('0);
    bus.Abort_i = 1'b0;
    vectors++;
    if (bus.Done_o !== 1'b0 || bus.Busy_o !== 1'b0 || bus.Cnt_Clk !== 16'd10) begin
      miscompares++;
      $display("[TB] FAIL abort_idle_hold: done=%b busy=%b clk=%0d required 0 0 10",
               bus.Done_o, bus.Busy_o, bus.Cnt_Clk);
    end
  endtask

  task automatic test_back_to_back;
    step('0);
    do_start(20, 0, '0);
    while (cyc < 5) step('0);
    bus.nCycles_i = 16'd3;
    bus.Start_i   = 1'b1;
    step('0);
    bus.Start_i   = 1'b0;
    vectors++;
    if (bus.Cnt_Clk !== 16'd6 || bus.Busy_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_in_run: clk=%0d busy=%b required clk=6 busy=1", bus.Cnt_Clk, bus.Busy_o);
    end
    while (cyc < 20) step('0);
    vectors++;
    if (bus.Done_o !== 1'b1 || bus.Cnt_Clk !== 16'd20) begin
      miscompares++;
      $display("[TB] FAIL start_in_run_end: done=%b clk=%0d required done=1 clk=20", bus.Done_o, bus.Cnt_Clk);
    end
  endtask

  task automatic test_reset_mid_run;
    step('0);
    step('0);
    bus.Channels = 4'b0001;
    do_start(40, 0, '0);
    step('0);
    step('0);
    step('0);
    vectors++;
    if (bus.Cnt_chann !== 16'h0001 || bus.Cnt_Clk !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_counts: ch=%h clk=%0d required ch=0001 clk=3", bus.Cnt_chann, bus.Cnt_Clk);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.Busy_o !== 1'b0 || bus.Done_o !== 1'b0 || bus.Cnt_Clk !== '0 ||
        bus.Cnt_chann !== '0 || bus.Cnt_pairs !== '0 || bus.Overflow_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_run: busy=%b done=%b clk=%h ch=%h pr=%h ovf=%h required all 0",
               bus.Busy_o, bus.Done_o, bus.Cnt_Clk, bus.Cnt_chann, bus.Cnt_pairs, bus.Overflow_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) step('0);
    vectors++;
    if (bus.Busy_o !== 1'b0 || bus.Cnt_Clk !== '0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: busy=%b clk=%0d required busy=0 clk=0", bus.Busy_o, bus.Cnt_Clk);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc           = 0;
    rst           = 1'b1;
    bus.Start_i   = 1'b0;
    bus.Abort_i   = 1'b0;
    bus.nCycles_i = '0;
    bus.Window_i  = '0;
    bus.Delays_i  = '0;
    bus.Channels  = '0;
    repeat (3) @(negedge clk);

    test_reset;
    test_basic_pair;
    test_delay_align(16'h0300, 24'h100000);
    test_delay_align(16'h0000, 24'h000000);
    test_window_edge(2, 24'h000001);
    test_window_edge(1, 24'h000000);
    test_three_window;
    test_saturation;
    test_zero_length;
    test_abort;
    test_back_to_back;
    test_reset_mid_run;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/coincidence_gate_counter.md
Name: coincidence_gate_counter

Overview:
Next-generation coincidence counter for the photon-detection front end. It takes NCHAN asynchronous detector lines, synchronises them and detects rising edges. Each channel is aligned by a programmable per-channel delay, then widened by a programmable coincidence window. Single-channel and all pairwise coincidence events are counted over a gated acquisition run, which is controlled by an IDLE/RUN/DONE state machine with start/abort, saturating counters and sticky overflow flags.

Parameters:
NCHAN, 4, number of detector channels (>=2); NPAIRS = NCHAN*(NCHAN-1)/2 is derived, not a parameter
CNTW, 16, width of each event/pair counter
CYCW, 16, width of gate length and clock counter
DLYW, 4, width of per-channel delay; max delay 2^DLYW-1 cycles
WINW, 4, width of coincidence window setting

Ports:
Clk  in  1  system clock; all logic on its rising edge
Rst  in  1  asynchronous, active-high reset
Start_i  in  1  start a run; level sampled each cycle
Abort_i  in  1  terminate a run without Done
nCycles_i  in  CYCW  gate length in clock cycles
Window_i  in  WINW  coincidence window, in extra cycles
Delays_i  in  NCHAN*DLYW  per-channel delay; channel i in bits [i*DLYW +: DLYW]
Channels  in  NCHAN  asynchronous detector inputs
Busy_o  out  1  high in RUN
Done_o  out  1  high in DONE
Cnt_Clk  out  CYCW  cycles elapsed in the current or last run
Cnt_chann  out  NCHAN*CNTW  per-channel event counts; channel i in [i*CNTW +: CNTW]
Cnt_pairs  out  NPAIRS*CNTW  pair counts; pair k in [k*CNTW +: CNTW]
Overflow_o  out  NCHAN+NPAIRS  sticky saturation flags; bits [NCHAN-1:0] = channels, remaining bits = pairs

Behaviour:
- Reset (Rst=1, asynchronous): state IDLE. All outputs 0. Synchronisers, delay lines, window counters and shadow registers are cleared.
- Input path: two-flop synchroniser per channel, then rising-edge detector P[i] = s2 & ~s2_d. A rising edge sampled at Clk edge k gives P[i] high for exactly one cycle, registered at edge k+2.
- Delay: Q[i] = P[i] delayed by D[i] cycles, using a shift line of depth 2^DLYW-1. D=0 means Q=P.
- Window: on Q[i]=1, window counter wc[i] is loaded with W; otherwise wc[i] decrements to 0. Open[i] = Q[i] | (wc[i]!=0). Two pulses coincide when their aligned separation is <= W cycles. W=0 means same-cycle coincidence only.
- Pair ordering: lexicographic over (i,j), i<j. For NCHAN=4: (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
- Counting: only in RUN, including the last RUN cycle.
  - Cnt_chann[i] += Q[i].
  - Cnt_pairs[k] += 1 when Open[i] & Open[j] & (Q[i] | Q[j]), i.e. one count per newly arriving pulse that finds the other window open.
  - Simultaneous Q[i] and Q[j] count once.
  - Each counter saturates at 2^CNTW-1 and sets its Overflow bit; it does not wrap.
- FSM:
  - IDLE or DONE with Start_i=1: on that edge, latch nCycles_i, Window_i and Delays_i into shadow registers (N, W, D), and clear all counters, Overflow_o, delay lines and window counters. Next state is RUN, or DONE directly if nCycles_i=0 (counts stay 0, Cnt_Clk=0).
  - RUN: Cnt_Clk increments every cycle. On the edge where Cnt_Clk becomes N, go to DONE. Exactly N counting cycles occur.
  - RUN with Abort_i=1: go to IDLE on that edge. Counts and Cnt_Clk are held; Done_o is never set. Abort has priority over end-of-gate.
  - Start_i during RUN is ignored. Abort_i outside RUN is ignored.
  - DONE: counts are held until the next Start_i or Rst. Pulses still in flight in the delay line are discarded.
- Input changes: nCycles_i, Window_i and Delays_i changes during RUN have no effect until the next Start.
- Busy_o and Done_o are decoded directly from state registers (glitch-free, no extra latency).

Test Plan:
- Reset mid-run: Rst pulsed 3 cycles into RUN with counts nonzero -> immediately all outputs 0, Busy_o=0; Start required to run again.
- Basic pair: nCycles=40, W=0, D=0; channels 0 and 1 rise in the same cycle 3 times -> Cnt_chann[0]=Cnt_chann[1]=3, Cnt_pairs[0]=3, other pairs 0; Done_o=1 and Cnt_Clk=40 exactly 40 cycles after RUN entry.
- Delay alignment: ch2 rises 3 cycles before ch3, W=0 -> with D[2]=3, Cnt_pairs[5]=1; with D[2]=0, Cnt_pairs[5]=0; Cnt_chann[2]=Cnt_chann[3]=1 in both cases.
- Window edge: ch0 rises at t, ch1 at t+2 -> W=2 gives Cnt_pairs[0]=1; W=1 gives 0. Three channels inside one window -> pairs 0, 1 and 3 each equal 1.
- Saturation: CNTW=4; 20 ch0 pulses in one run -> Cnt_chann[0]=15, Overflow_o[0]=1, other bits 0; the next Start clears both.
- Control corners: Start with nCycles=0 -> DONE next cycle, all counts 0. Abort at cycle 10 of a 40-cycle run -> IDLE, Cnt_Clk=10, Done_o=0. Start during RUN -> no effect.
